combilogic_resp_checker: RTL and testbench
==========================================

# combilogic_resp_checker

Synthesizable response checker for the 4-input combinational `combilogic` block. It is the receiving end of the exhaustive 16-vector stimulus sequence ({a,b,c,d} = 0..15). It samples the block output `y` for each applied vector and compares it against a parameterized truth table. It reports the error count, the first failing vector, sequence errors and a pass/done verdict. It sits beside `combilogic` in self-checking benches and on-chip BIST wrappers, and replaces waveform inspection.

## Interface
- `EXP_TT`, default 16'h0000, expected truth table; bit i is the expected `y` for vector i, where vector = {a,b,c,d}.
- Clock is `clk` and reset is `rst_n`. There is one clock domain. Reset is synchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: single-cycle pulse that begins a checking run.
- `vec_valid` in 1: `vec`/`y` are valid this cycle; at most one vector is accepted per cycle.
- `vec` in 4: applied vector {a,b,c,d}.
- `y` in 1: `combilogic` output for `vec`.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until next `start` or reset.
- `pass` out 1: valid when `done`=1; 1 if err_cnt==0 and seq_err==0.
- `err_cnt` out 5: number of mismatching vectors, 0..16.
- `first_fail` out 4: vector index of the first mismatch.
- `first_fail_vld` out 1: `first_fail` holds a captured value.
- `seq_err` out 1: sticky; a vector arrived out of order.
- `signature` out 16: MISR signature; present only with `COMBI_CHK_SIGNATURE_EN`.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset forces IDLE.
- **IDLE**
  - `vec_valid` is ignored.
  - `start` clears err_cnt, first_fail, first_fail_vld and seq_err, sets exp_idx=0, and moves to RUN.
- **RUN**
  - Each `vec_valid` cycle accepts one vector.
  - mismatch = (y != EXP_TT[vec]).
  - On mismatch:
    - err_cnt increments.
    - If first_fail_vld=0, first_fail is set to vec and first_fail_vld to 1.
  - If vec != exp_idx, seq_err sets.
    - The comparison still uses the received `vec`.
    - exp_idx still advances.
  - exp_idx increments as a 4-bit counter.
  - Accepting the vector with exp_idx==15 moves the FSM to DONE; the wrap to 0 is not used.
  - `start` during RUN is ignored.
- **DONE**
  - done=1 and pass is valid.
  - `vec_valid` is ignored; outputs hold.
  - `start` clears results and re-enters RUN.
- `start` and `vec_valid` in the same IDLE/DONE cycle: the run starts and that vector is NOT accepted.
- err_cnt never exceeds 16, so it needs no saturation.
- Reset mid-run:
  - Returns to IDLE on the next edge.
  - All outputs take their reset values.
  - The partial run is discarded.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, pass=0, err_cnt=0, first_fail=0, first_fail_vld=0, seq_err=0, signature=16'hFFFF.
- busy rises the cycle after `start` and falls the cycle after the 16th accepted vector.
- err_cnt, first_fail and seq_err update the cycle after the accepting `vec_valid` edge (latency 1).
- done and pass assert together, 1 cycle after the 16th accepted vector.
- No minimum spacing between vectors; back-to-back `vec_valid` is legal.

## Configuration
- `COMBI_CHK_SIGNATURE_EN` **defined**:
  - A 16-bit MISR with polynomial x^16+x^14+x^13+x^11+1 is built in.
  - It is seeded to 16'hFFFF on `start`.
  - Each accepted vector updates it: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {11'b0, vec, y}.
  - The `signature` port exists and holds its value in DONE.
- **Undefined**: no MISR logic and no `signature` port. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, with `start` and `vec_valid` toggling -> busy=0, done=0, pass=0, err_cnt=0, first_fail_vld=0, seq_err=0.
- Golden run, EXP_TT=16'hA5C3:
  - Stimulus: start, then vec 0..15 with y=EXP_TT[vec], one every 10 cycles.
  - Required: done=1 and pass=1, err_cnt=0, busy=0 one cycle after the 16th vector.
- Single fault: golden run with y inverted at vec=5 -> err_cnt=1, first_fail=5, first_fail_vld=1, pass=0.
- Two faults plus order error:
  - Stimulus: order 0,1,3,2,4..15 with y inverted at vec 9 and 12.
  - Required: seq_err=1, err_cnt=2, first_fail=9, pass=0.
- Reset mid-run, then back-to-back run:
  - Stimulus: assert rst_n=0 after 7 vectors; then start and send 16 back-to-back golden vectors.
  - Required: outputs clear after the reset; the new run gives done=1 and pass=1 exactly 1 cycle after the last vector.
- With `COMBI_CHK_SIGNATURE_EN`:
  - The golden-run signature matches the bench MISR model.
  - The single-fault run yields a different signature.
  - `start` in DONE reseeds the signature to 16'hFFFF.

Source files
------------

// File: rtl/combilogic_resp_checker.sv
// rtl/combilogic_resp_checker.sv - checks combilogic y over the 16-vector sweep against EXP_TT.
// Optional MISR signature output enabled by defining COMBI_CHK_SIGNATURE_EN.
module combilogic_resp_checker #(
    parameter logic [15:0] EXP_TT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        vec_valid,
    input  logic [3:0]  vec,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [3:0]  first_fail,
    output logic        first_fail_vld,
    output logic        seq_err
`ifdef COMBI_CHK_SIGNATURE_EN
    ,
    output logic [15:0] signature
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_exp_idx;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [4:0]  r_err_cnt;
    logic [3:0]  r_first_fail;
    logic        r_first_fail_vld;
    logic        r_seq_err;

    logic        w_mismatch;
    logic [4:0]  w_err_cnt_nxt;
    logic        w_seq_err_nxt;
    logic        w_last;

    assign w_mismatch    = (y != EXP_TT[vec]);
    assign w_err_cnt_nxt = r_err_cnt + {4'b0000, w_mismatch};
    assign w_seq_err_nxt = r_seq_err | (vec != r_exp_idx);
    assign w_last        = (r_exp_idx == 4'hF);

`ifdef COMBI_CHK_SIGNATURE_EN
    logic [15:0] r_sig;
    logic [15:0] w_sig_nxt;

    // Shift with x^16+x^14+x^13+x^11+1 feedback, then fold in the observed {vec,y}.
    assign w_sig_nxt = {r_sig[14:0], r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10]}
                       ^ {11'b0, vec, y};
    assign signature = r_sig;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig <= 16'hFFFF;
        end else if ((r_state != ST_RUN) && start) begin
            r_sig <= 16'hFFFF;
        end else if ((r_state == ST_RUN) && vec_valid) begin
            r_sig <= w_sig_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_exp_idx        <= 4'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_cnt        <= 5'd0;
            r_first_fail     <= 4'd0;
            r_first_fail_vld <= 1'b0;
            r_seq_err        <= 1'b0;
        end else begin
            case (r_state)
                // A vector coincident with start is deliberately dropped.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state          <= ST_RUN;
                        r_exp_idx        <= 4'd0;
                        r_busy           <= 1'b1;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_err_cnt        <= 5'd0;
                        r_first_fail     <= 4'd0;
                        r_first_fail_vld <= 1'b0;
                        r_seq_err        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (vec_valid) begin
                        r_err_cnt <= w_err_cnt_nxt;
                        r_seq_err <= w_seq_err_nxt;
                        r_exp_idx <= r_exp_idx + 4'd1;
                        if (w_mismatch && !r_first_fail_vld) begin
                            r_first_fail     <= vec;
                            r_first_fail_vld <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_cnt_nxt == 5'd0) && !w_seq_err_nxt;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_fail     = r_first_fail;
    assign first_fail_vld = r_first_fail_vld;
    assign seq_err        = r_seq_err;

endmodule

// File: tb/tb_combilogic_resp_checker.sv
// tb/tb_combilogic_resp_checker.sv - scoreboard bench for combilogic_resp_checker.
// Signature checks follow COMBI_CHK_SIGNATURE_EN.
module tb_combilogic_resp_checker;

    localparam logic [15:0] TT = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        vec_valid = 1'b0;
    logic [3:0]  vec = 4'd0;
    logic        y = 1'b0;
    logic        busy, done, pass, first_fail_vld, seq_err;
    logic [4:0]  err_cnt;
    logic [3:0]  first_fail;
`ifdef COMBI_CHK_SIGNATURE_EN
    logic [15:0] signature;
`endif

    combilogic_resp_checker #(.EXP_TT(TT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .vec_valid(vec_valid),
        .vec(vec),
        .y(y),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_cnt(err_cnt),
        .first_fail(first_fail),
        .first_fail_vld(first_fail_vld),
        .seq_err(seq_err)
`ifdef COMBI_CHK_SIGNATURE_EN
        ,
        .signature(signature)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [15:0] tt_v = TT;

    typedef struct {
        int          err;
        int          ff;
        bit          ffv;
        bit          seq;
        bit          pas;
        int          cyc;
        logic [15:0] sig;
    } exp_t;

    exp_t        sbq[$];
    logic [3:0]  s_vec[16];
    logic        s_y[16];
    bit          prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] v, input logic yy);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {11'b0, v, yy};
    endfunction

    // Reference: results follow directly from the list of observed (vec, y) pairs.
    task automatic build_expect(output exp_t e);
        logic [15:0] s;
        e.err = 0; e.ff = 0; e.ffv = 0; e.seq = 0; e.cyc = 0;
        s = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (s_y[i] != tt_v[s_vec[i]]) begin
                e.err++;
                if (!e.ffv) begin
                    e.ffv = 1;
                    e.ff  = int'(s_vec[i]);
                end
            end
            if (int'(s_vec[i]) != i) e.seq = 1;
            s = misr_step(s, s_vec[i], s_y[i]);
        end
        e.pas = (e.err == 0) && !e.seq;
        e.sig = s;
    endtask

    task automatic set_golden();
        for (int i = 0; i < 16; i++) begin
            s_vec[i] = 4'(i);
            s_y[i]   = tt_v[i];
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending run");
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("pass", pass, e.pas);
                    chk("err_cnt", err_cnt, e.err);
                    chk("first_fail_vld", first_fail_vld, e.ffv);
                    chk("first_fail", first_fail, e.ff);
                    chk("seq_err", seq_err, e.seq);
                    chk("busy_at_done", busy, 0);
`ifdef COMBI_CHK_SIGNATURE_EN
                    chk("signature", signature, e.sig);
`endif
                end
            end
            prev_done = done;
        end
    end

    task automatic do_run(input int gap, input bit start_vv, input bit inj_start);
        exp_t e;
        build_expect(e);
        @(posedge clk); #1;
        start = 1'b1; vec_valid = start_vv; vec = 4'd0; y = ~tt_v[0];
        @(posedge clk); #1;
        start = 1'b0; vec_valid = 1'b0;
        chk("busy_rise", busy, 1);
        chk("done_clr", done, 0);
        chk("pass_clr", pass, 0);
        chk("err_clr", err_cnt, 0);
        chk("ffv_clr", first_fail_vld, 0);
        chk("seq_clr", seq_err, 0);
`ifdef COMBI_CHK_SIGNATURE_EN
        chk("sig_seed", signature, 16'hFFFF);
`endif
        for (int i = 0; i < 16; i++) begin
            vec_valid = 1'b1;
            vec = s_vec[i];
            y = s_y[i];
            start = inj_start && (i == 5);
            @(posedge clk); #1;
            vec_valid = 1'b0;
            start = 1'b0;
            if (i == 15) begin
                e.cyc = cyc;
                sbq.push_back(e);
                chk("busy_fall", busy, 0);
            end else begin
                repeat (gap - 1) begin @(posedge clk); #1; end
            end
        end
        @(negedge clk); #1;
        chk("sb_drained", sbq.size(), 0);
    endtask

    initial begin : stim
        // Reset with inputs toggling.
        repeat (2) begin
            @(posedge clk); #1;
            start = ~start;
            vec_valid = ~vec_valid;
            vec = 4'($urandom_range(0, 15));
            y = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ff", first_fail, 0);
        chk("rst_ffv", first_fail_vld, 0);
        chk("rst_seq", seq_err, 0);
`ifdef COMBI_CHK_SIGNATURE_EN
        chk("rst_sig", signature, 16'hFFFF);
`endif
        start = 1'b0; vec_valid = 1'b0; rst_n = 1'b1;

        // Vectors in IDLE are ignored.
        @(posedge clk); #1;
        vec_valid = 1'b1; vec = 4'd3; y = ~tt_v[3];
        @(posedge clk); #1;
        vec_valid = 1'b0;
        chk("idle_ignore_err", err_cnt, 0);
        chk("idle_ignore_busy", busy, 0);

        set_golden();
        do_run(10, 1'b0, 1'b0);

        // Vectors in DONE are ignored and outputs hold.
        vec_valid = 1'b1; vec = 4'd7; y = ~tt_v[7];
        @(posedge clk); #1;
        vec_valid = 1'b0;
        chk("done_hold_err", err_cnt, 0);
        chk("done_hold_done", done, 1);
        chk("done_hold_pass", pass, 1);

        // Single fault at vec 5 (also restarts from DONE).
        set_golden();
        s_y[5] = ~s_y[5];
        do_run(10, 1'b0, 1'b0);

        // Order 0,1,3,2,4.. with faults at vec 9 and 12; coincident start+vec dropped.
        set_golden();
        s_vec[2] = 4'd3; s_vec[3] = 4'd2;
        s_y[2] = tt_v[3]; s_y[3] = tt_v[2];
        s_y[9] = ~s_y[9]; s_y[12] = ~s_y[12];
        do_run(3, 1'b1, 1'b1);

        // Reset mid-run after 7 vectors.
        set_golden();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            vec_valid = 1'b1; vec = s_vec[i]; y = (i == 2) ? ~s_y[i] : s_y[i];
            @(posedge clk); #1;
        end
        vec_valid = 1'b0;
        chk("mid_err", err_cnt, 1);
        chk("mid_ff", first_fail, 2);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mrst_busy", busy, 0);
        chk("mrst_err", err_cnt, 0);
        chk("mrst_ff", first_fail, 0);
        chk("mrst_ffv", first_fail_vld, 0);
        chk("mrst_done", done, 0);
        chk("mrst_seq", seq_err, 0);
        do_run(1, 1'b0, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                s_vec[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(i);
                s_y[i]   = tt_v[s_vec[i]] ^ ($urandom_range(0, 3) == 0);
            end
            do_run(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_final", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
